// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int         REG_AW        = 4;        // register address width
    localparam int         NUM_REGS      = 16;       // R0..R15
    localparam logic [3:0] COND_AL       = 4'b1110;  // "always" condition code
    localparam int         CNT_W_DEFAULT = 2;        // pending-write counter width

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one target.
// Simultaneous inc and dec leave the count unchanged; a dec at zero holds
// the count at zero and reports underflow for that cycle.
module pend_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         full,
    output logic         underflow
);

    localparam logic [W-1:0] ONE = W'(1);

    assign zero      = (count == '0);
    assign full      = &count;
    assign underflow = dec & zero;

    // Count up on issue, down on retire, clamped at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + ONE;
        end else if (dec && !inc && !zero) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard controller: tracks pending register writes and pending
// flag updates from ID issue to WB retire, stalls ID on RAW / flag / structural
// hazards, freezes on memory busy, flushes on taken branch.
// Outputs hazard/freeze/flush are pure combinational level signals (no
// handshake): the pipeline samples them every rising edge.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        id_src1,
    input  logic              id_use_src1,
    input  logic [3:0]        id_src2,
    input  logic              id_two_src,
    input  logic [3:0]        id_cond,
    input  logic              id_wb_en,
    input  logic [3:0]        id_dest,
    input  logic              id_s,
    input  logic              id_cond_pass,
    input  logic              exe_branch_taken,
    input  logic              wb_enable,
    input  logic [3:0]        wb_dest,
    input  logic              exe_s_done,
    input  logic              mem_busy,
    output logic              hazard,
    output logic              freeze,
    output logic              flush,
    output logic              sb_error,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic                retire;
    logic                flag_done;
    logic                issue;

    logic [NUM_REGS-1:0] inc_r;
    logic [NUM_REGS-1:0] dec_r;
    logic [NUM_REGS-1:0] zero_r;
    logic [NUM_REGS-1:0] full_r;
    logic [NUM_REGS-1:0] uflow_r;
    logic [NUM_REGS-1:0] busy_r;
    logic [CNT_W-1:0]    cnt_r [NUM_REGS];

    logic                inc_f;
    logic                dec_f;
    logic                zero_f;
    logic                full_f;
    logic                uflow_f;
    logic                busy_f;
    logic [CNT_W-1:0]    cnt_f;

    assign freeze    = mem_busy;
    assign flush     = exe_branch_taken & ~freeze;
    assign retire    = wb_enable & ~freeze;
    assign flag_done = exe_s_done & ~freeze;
    assign issue     = id_cond_pass & ~hazard & ~flush & ~freeze;

    // One counter per architectural register. A target is "busy" unless its
    // last pending write retires this very cycle (register file writes in the
    // first half-cycle, so ID already sees the value).
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign inc_r[g]  = issue & id_wb_en & (id_dest == REG_AW'(g));
        assign dec_r[g]  = retire & (wb_dest == REG_AW'(g));
        assign busy_r[g] = ~zero_r[g] & ~(dec_r[g] & (cnt_r[g] == ONE));

        pend_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_r[g]),
            .dec       (dec_r[g]),
            .count     (cnt_r[g]),
            .zero      (zero_r[g]),
            .full      (full_r[g]),
            .underflow (uflow_r[g])
        );
    end

    assign inc_f  = issue & id_s;
    assign dec_f  = flag_done;
    assign busy_f = ~zero_f & ~(dec_f & (cnt_f == ONE));

    pend_counter #(.W(CNT_W)) u_flag_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc_f),
        .dec       (dec_f),
        .count     (cnt_f),
        .zero      (zero_f),
        .full      (full_f),
        .underflow (uflow_f)
    );

    // Stall ID on a source/flag read of pending data or a full target counter.
    always_comb begin
        hazard = 1'b0;
        if (!flush) begin
            hazard = (id_use_src1 & busy_r[id_src1])
                   | (id_two_src  & busy_r[id_src2])
                   | ((id_cond != COND_AL) & busy_f)
                   | (id_wb_en & full_r[id_dest])
                   | (id_s & full_f);
        end
    end

    // Sticky error on any retire or flag-done with nothing pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_error <= 1'b0;
        end else if (|uflow_r || uflow_f) begin
            sb_error <= 1'b1;
        end
    end

    // Saturating count of unfrozen cycles spent stalled on a hazard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (hazard && !freeze && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, all
// checked against a behavioural model through an expected-value queue.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int PERF_W = 16;
    localparam int CNT_W  = 2;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int MAXS   = (1 << PERF_W) - 1;
    localparam int OUT_W  = 4 + PERF_W;

    typedef struct packed {
        logic [3:0] src1;
        logic       use1;
        logic [3:0] src2;
        logic       two;
        logic [3:0] cond;
        logic       wb_en;
        logic [3:0] dest;
        logic       s;
        logic       pass;
        logic       br;
        logic       wbe;
        logic [3:0] wbd;
        logic       sdone;
        logic       busy;
    } stim_t;

    logic              clk;
    logic              rst;
    logic [3:0]        id_src1;
    logic              id_use_src1;
    logic [3:0]        id_src2;
    logic              id_two_src;
    logic [3:0]        id_cond;
    logic              id_wb_en;
    logic [3:0]        id_dest;
    logic              id_s;
    logic              id_cond_pass;
    logic              exe_branch_taken;
    logic              wb_enable;
    logic [3:0]        wb_dest;
    logic              exe_s_done;
    logic              mem_busy;
    logic              hazard;
    logic              freeze;
    logic              flush;
    logic              sb_error;
    logic [PERF_W-1:0] stall_cycles;

    logic [OUT_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: plain pending-write counts.
    int m_pend[16];
    int m_pend_f;
    bit m_err;
    int m_stall;

    hazard_scoreboard #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_src1          (id_src1),
        .id_use_src1      (id_use_src1),
        .id_src2          (id_src2),
        .id_two_src       (id_two_src),
        .id_cond          (id_cond),
        .id_wb_en         (id_wb_en),
        .id_dest          (id_dest),
        .id_s             (id_s),
        .id_cond_pass     (id_cond_pass),
        .exe_branch_taken (exe_branch_taken),
        .wb_enable        (wb_enable),
        .wb_dest          (wb_dest),
        .exe_s_done       (exe_s_done),
        .mem_busy         (mem_busy),
        .hazard           (hazard),
        .freeze           (freeze),
        .flush            (flush),
        .sb_error         (sb_error),
        .stall_cycles     (stall_cycles)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.cond = COND_AL;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_src1          = s.src1;
        id_use_src1      = s.use1;
        id_src2          = s.src2;
        id_two_src       = s.two;
        id_cond          = s.cond;
        id_wb_en         = s.wb_en;
        id_dest          = s.dest;
        id_s             = s.s;
        id_cond_pass     = s.pass;
        exe_branch_taken = s.br;
        wb_enable        = s.wbe;
        wb_dest          = s.wbd;
        exe_s_done       = s.sdone;
        mem_busy         = s.busy;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 16; r++) m_pend[r] = 0;
        m_pend_f = 0;
        m_err    = 0;
        m_stall  = 0;
    endtask

    // A reader waits while something is still outstanding after this
    // cycle's retirement is taken into account.
    function automatic bit still_pending(input int cnt, input bit retiring);
        return (cnt - (retiring ? 1 : 0)) > 0;
    endfunction

    task automatic model_eval(input stim_t s, output bit hz, output bit fr,
                              output bit fl, output bit iss);
        bit ret;
        bit fd;
        fr  = s.busy;
        fl  = s.br && !fr;
        ret = s.wbe && !fr;
        fd  = s.sdone && !fr;
        hz  = !fl && ((s.use1 && still_pending(m_pend[s.src1], ret && s.wbd == s.src1)) ||
                      (s.two  && still_pending(m_pend[s.src2], ret && s.wbd == s.src2)) ||
                      (s.cond != COND_AL && still_pending(m_pend_f, fd)) ||
                      (s.wb_en && m_pend[s.dest] == MAXC) ||
                      (s.s && m_pend_f == MAXC));
        iss = s.pass && !hz && !fl && !fr;
    endtask

    task automatic model_advance(input stim_t s, input bit hz, input bit fr, input bit iss);
        bit ret;
        bit fd;
        bit up;
        bit dn;
        ret = s.wbe && !fr;
        fd  = s.sdone && !fr;
        for (int r = 0; r < 16; r++) begin
            up = iss && s.wb_en && s.dest == r;
            dn = ret && s.wbd == r;
            if (dn && m_pend[r] == 0) m_err = 1;
            if (up && !dn && m_pend[r] < MAXC) m_pend[r]++;
            else if (dn && !up && m_pend[r] > 0) m_pend[r]--;
        end
        up = iss && s.s;
        if (fd && m_pend_f == 0) m_err = 1;
        if (up && !fd && m_pend_f < MAXC) m_pend_f++;
        else if (fd && !up && m_pend_f > 0) m_pend_f--;
        if (hz && !fr && m_stall < MAXS) m_stall++;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input stim_t s);
        bit hz;
        bit fr;
        bit fl;
        bit iss;
        @(posedge clk);
        #1;
        apply(s);
        model_eval(s, hz, fr, fl, iss);
        exp_q.push_back({hz, fr, fl, m_err, PERF_W'(m_stall)});
        model_advance(s, hz, fr, iss);
    endtask

    task automatic reset_mid(input stim_t s);
        bit hz;
        bit fr;
        bit fl;
        bit iss;
        @(posedge clk);
        #1;
        apply(s);
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        model_eval(s, hz, fr, fl, iss);
        check("rst_hazard", hazard, hz);
        check("rst_freeze", freeze, fr);
        check("rst_flush", flush, fl);
        check("rst_sb_error", sb_error, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        apply(idle());
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s       = idle();
        s.src1  = 4'($urandom_range(0, 7));
        s.use1  = 1'($urandom_range(0, 1));
        s.src2  = 4'($urandom_range(0, 7));
        s.two   = 1'($urandom_range(0, 1));
        s.cond  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : COND_AL;
        s.wb_en = 1'($urandom_range(0, 1));
        s.dest  = 4'($urandom_range(0, 7));
        s.s     = ($urandom_range(0, 3) == 0);
        s.pass  = ($urandom_range(0, 7) != 0);
        s.br    = ($urandom_range(0, 9) == 0);
        s.wbd   = 4'($urandom_range(0, 7));
        s.wbe   = 1'($urandom_range(0, 1));
        if (m_pend[s.wbd] == 0 && $urandom_range(0, 19) != 0) s.wbe = 1'b0;
        s.sdone = (m_pend_f > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
        s.busy  = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [OUT_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hazard", hazard, e[OUT_W-1]);
                check("freeze", freeze, e[OUT_W-2]);
                check("flush", flush, e[OUT_W-3]);
                check("sb_error", sb_error, e[OUT_W-4]);
                check("stall_cycles", stall_cycles, e[PERF_W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        stim_t dep;
        int    guard;

        // Reset state.
        rst = 1'b0;
        apply(idle());
        model_clear();
        #3;
        check("reset_hazard", hazard, 0);
        check("reset_freeze", freeze, 0);
        check("reset_flush", flush, 0);
        check("reset_sb_error", sb_error, 0);
        check("reset_stall_cycles", stall_cycles, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;

        // Dependent ALU pair: ADD R1 then SUB reading R1.
        s = idle(); s.wb_en = 1; s.dest = 1; s.pass = 1;
        drive(s);
        dep = idle(); dep.use1 = 1; dep.src1 = 1; dep.wb_en = 1; dep.dest = 3; dep.pass = 1;
        repeat (3) drive(dep);
        dep.wbe = 1; dep.wbd = 1;
        drive(dep);
        #1;
        check("pair_bypass_hazard", hazard, 0);
        s = idle(); s.wbe = 1; s.wbd = 3;
        drive(s);
        #1;
        check("pair_stall_cycles", stall_cycles, 3);

        // Flag dependency: CMP then ADDEQ; ADD (AL) unaffected.
        s = idle(); s.s = 1; s.pass = 1;
        drive(s);
        dep = idle(); dep.cond = 4'b0000; dep.wb_en = 1; dep.dest = 4; dep.pass = 1;
        drive(dep);
        #1;
        check("flag_hazard", hazard, 1);
        drive(dep);
        s = dep; s.cond = COND_AL;
        drive(s);
        #1;
        check("al_no_flag_hazard", hazard, 0);
        dep.sdone = 1;
        drive(dep);
        #1;
        check("flag_done_bypass", hazard, 0);
        s = idle(); s.wbe = 1; s.wbd = 4;
        repeat (2) drive(s);

        // Branch flush with a dependent instruction in ID.
        s = idle(); s.wb_en = 1; s.dest = 6; s.pass = 1;
        drive(s);
        dep = idle(); dep.use1 = 1; dep.src1 = 6; dep.pass = 1; dep.br = 1;
        drive(dep);
        #1;
        check("flush_asserted", flush, 1);
        check("flush_hides_hazard", hazard, 0);
        dep.br = 0;
        drive(dep);
        #1;
        check("after_flush_hazard", hazard, 1);
        dep.wbe = 1; dep.wbd = 6;
        drive(dep);

        // Memory freeze during pending LDR R2 with WB attempting retire.
        s = idle(); s.wb_en = 1; s.dest = 2; s.pass = 1;
        drive(s);
        dep = idle(); dep.use1 = 1; dep.src1 = 2; dep.pass = 1; dep.wb_en = 1; dep.dest = 8;
        dep.busy = 1; dep.wbe = 1; dep.wbd = 2;
        repeat (4) begin
            drive(dep);
            #1;
            check("freeze_asserted", freeze, 1);
            check("freeze_hazard_computed", hazard, 1);
        end
        dep.busy = 0;
        drive(dep);
        #1;
        check("unfreeze_retire_bypass", hazard, 0);
        s = idle(); s.wbe = 1; s.wbd = 8;
        drive(s);

        // Saturation: three writes to R5, a fourth stalls.
        s = idle(); s.wb_en = 1; s.dest = 5; s.pass = 1;
        repeat (3) drive(s);
        drive(s);
        #1;
        check("sat_hazard", hazard, 1);
        drive(s);
        #1;
        check("sat_hazard_held", hazard, 1);
        s = idle(); s.wbe = 1; s.wbd = 5;
        repeat (3) drive(s);

        // Underflow: retire R7 with nothing pending.
        drive(s);
        s.wbd = 7;
        drive(s);
        drive(idle());
        #1;
        check("underflow_sb_error", sb_error, 1);
        drive(idle());
        #1;
        check("underflow_sticky", sb_error, 1);

        // Reset in the middle of a stall.
        s = idle(); s.wb_en = 1; s.dest = 9; s.pass = 1;
        drive(s);
        dep = idle(); dep.use1 = 1; dep.src1 = 9; dep.pass = 1;
        drive(dep);
        reset_mid(dep);

        // Random traffic with one more asynchronous reset in the middle.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) reset_mid(rand_stim());
            else drive(rand_stim());
        end
        drive(idle());

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
